dzcpu_useq: RTL and testbench
=============================

Name: dzcpu_useq

Overview:
Parametrised microcode sequencer for the next-generation dzcpu core. Replaces the fixed 8-bit uPC counter and hard-wired EOF mux with a configurable sequencer supporting jumps, micro-subroutine CALL/RET on a bounded stack, memory wait-states and abort. It sits between the opcode flow-index LUTs and the microcode ROM. It drives the ROM address, and the datapath commit enable that gates all register, flag and PC writes.

Parameters:
UPC_W, 8, width of micro program counter / ROM address
UOP_W, 16, width of micro-op word from ROM (must be >= UPC_W+5)
STACK_DEPTH, 4, number of CALL return-address entries (>=1)
LVL_W, 3, width of oStackLevel (must hold 0..STACK_DEPTH)

Ports:
iClock  in  1  rising-edge clock
iReset  in  1  reset, active-low, synchronous (0 = reset on next edge)
iStart  in  1  start new macro-instruction flow; sampled only in IDLE
iFlowIdx  in  UPC_W  flow entry address from opcode LUT, valid with iStart
iUop  in  UOP_W  micro-op read combinationally from ROM at oUpc
iFlags  in  4  condition flags {z,n,h,c} = bits [3:0]
iMemReady  in  1  memory handshake; completes a WAIT micro-op
iAbort  in  1  abandon current flow (interrupt/debug)
oUpc  out  UPC_W  micro program counter / ROM address
oExec  out  1  commit enable for current micro-op (combinational)
oBusy  out  1  high in RUN or WAIT
oDone  out  1  one-cycle pulse after a taken EOF
oFault  out  1  sticky stack over/underflow
oStackLevel  out  LVL_W  current stack occupancy

Behaviour:
- Seq field SQ = iUop[UOP_W-1:UOP_W-3]. Cond select CS = iUop[UOP_W-4:UOP_W-5] picks iFlags[CS]. Target T = iUop[UPC_W-1:0].
- SQ encoding: 000 NEXT, 001 EOF, 010 EOF if flag=1, 011 EOF if flag=0, 100 JMP T, 101 CALL T, 110 RET, 111 WAIT.
- States: IDLE, RUN, FAULT. WAIT is RUN with a stalled micro-op.
- Reset (iReset=0 at edge): state IDLE, oUpc=0, stack level 0, oDone=0, oFault=0. Stack contents don't care. Reset overrides every other input.
- IDLE: oExec=0, oBusy=0. If iStart=1 then oUpc<=iFlowIdx and go to RUN. Otherwise hold oUpc.
- RUN: oBusy=1, oExec=1 except WAIT with iMemReady=0. Per executed micro-op:
  - NEXT: oUpc<=oUpc+1, wrapping modulo 2^UPC_W.
  - EOF taken: go to IDLE, oDone<=1 for next cycle only, stack level<=0 (silent flush), oUpc holds.
  - EOF not taken: treated as NEXT.
  - JMP: oUpc<=T.
  - CALL: if level<STACK_DEPTH, push oUpc+1 (wrapped), level+1, oUpc<=T. Else go to FAULT.
  - RET: if level>0, pop into oUpc, level-1. Else go to FAULT.
  - WAIT: iMemReady=0 holds oUpc with oExec=0. iMemReady=1 advances as NEXT with oExec=1 in that cycle.
- iAbort=1 in RUN: go to IDLE next edge, oExec forced 0 that cycle, stack level<=0, no oDone, oUpc holds. iAbort is ignored in IDLE and FAULT.
- FAULT: oFault=1, oExec=0, oBusy=0. oUpc and level are frozen. iStart/iAbort are ignored; only reset exits. The faulting micro-op has oExec=0.
- oDone is registered. A new iStart is accepted in the same cycle oDone is high, which gives back-to-back flows with one IDLE cycle.
- iStart asserted in RUN is ignored and not queued.
- Every micro-op takes 1 cycle, plus stall cycles for WAIT.

Test Plan:
- Reset/start: hold iReset=0 for 2 cycles -> oUpc=0, oBusy=0, oDone=0, oFault=0. Release, iStart=1, iFlowIdx=8'h20 -> next cycle oUpc=8'h20, oBusy=1, oExec=1.
- Linear flow plus EOF: ROM 20=NEXT, 21=NEXT, 22=EOF -> oUpc 20,21,22 over 3 cycles. Then IDLE with oDone=1 for exactly 1 cycle. iStart with idx 30 during oDone -> oUpc=30 next cycle.
- Conditional EOF: 22=EOF-if-z(CS=3). iFlags=4'b0000 -> oUpc=23 and flow continues. iFlags=4'b1000 -> IDLE with oDone pulse.
- CALL/RET nest: 40=CALL 60, 60=CALL 70, 70=RET, 61=RET, 41=EOF -> oUpc sequence 40,60,70,61,41. oStackLevel sequence 0,1,2,1,0 then oDone.
- Stack faults: STACK_DEPTH=4, five nested CALLs -> 5th CALL gives oFault=1, oExec=0, oStackLevel=4, oUpc frozen. Separately, RET at level 0 -> oFault=1. Only iReset=0 clears oFault.
- WAIT/abort/wrap: WAIT at 50 with iMemReady=0 for 3 cycles -> oUpc=50, oExec=0; iMemReady=1 -> oExec=1, oUpc=51. NEXT at 8'hFF -> oUpc=8'h00. iAbort mid-flow at level 2 -> IDLE, level 0, oDone stays 0.

Source files
------------

// File: rtl/dzcpu_useq.sv
// Microcode sequencer for the dzcpu core: drives the micro-ROM address and the
// per-micro-op commit enable, with JMP, CALL/RET on a bounded stack, WAIT and abort.
module dzcpu_useq #(
  parameter int UPC_W       = 8,
  parameter int UOP_W       = 16,
  parameter int STACK_DEPTH = 4,
  parameter int LVL_W       = 3
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iStart,
  input  logic [UPC_W-1:0] iFlowIdx,
  input  logic [UOP_W-1:0] iUop,
  input  logic [3:0]       iFlags,
  input  logic             iMemReady,
  input  logic             iAbort,
  output logic [UPC_W-1:0] oUpc,
  output logic             oExec,
  output logic             oBusy,
  output logic             oDone,
  output logic             oFault,
  output logic [LVL_W-1:0] oStackLevel
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] SQ_NEXT = 3'b000;
  localparam logic [2:0] SQ_EOF  = 3'b001;
  localparam logic [2:0] SQ_EOFT = 3'b010;
  localparam logic [2:0] SQ_EOFF = 3'b011;
  localparam logic [2:0] SQ_JMP  = 3'b100;
  localparam logic [2:0] SQ_CALL = 3'b101;
  localparam logic [2:0] SQ_RET  = 3'b110;
  localparam logic [2:0] SQ_WAIT = 3'b111;

  typedef enum logic [1:0] {sIdle = 2'd0, sRun = 2'd1, sFault = 2'd2} state_t;

  state_t           state, stateNext;
  logic [UPC_W-1:0] upc, upcNext, upcInc, target;
  logic [LVL_W-1:0] level, levelNext;
  logic             done, doneNext;
  logic [UPC_W-1:0] stack [STACK_DEPTH];
  logic [IDX_W-1:0] pushIdx, popIdx;
  logic [2:0]       sq;
  logic [1:0]       cs;
  logic             flag, canPush, canPop, eofTaken, stall, stackErr, push;

  // Micro-op field decode; bits between the cond select and the target are spare.
  assign sq       = iUop[UOP_W-1 -: 3];
  assign cs       = iUop[UOP_W-4 -: 2];
  assign flag     = iFlags[cs];
  assign target   = iUop[UPC_W-1:0];
  assign upcInc   = upc + UPC_W'(1);
  assign canPush  = level < LVL_W'(STACK_DEPTH);
  assign canPop   = level != '0;
  assign eofTaken = (sq == SQ_EOF) || (sq == SQ_EOFT && flag) || (sq == SQ_EOFF && !flag);
  assign stall    = (sq == SQ_WAIT) && !iMemReady;
  assign stackErr = (sq == SQ_CALL && !canPush) || (sq == SQ_RET && !canPop);
  assign pushIdx  = IDX_W'(level);
  assign popIdx   = IDX_W'(level - LVL_W'(1));
  assign push     = (state == sRun) && !iAbort && (sq == SQ_CALL) && canPush;

  if (UOP_W > UPC_W + 5) begin : gSpare
    logic unusedUop;
    assign unusedUop = ^iUop[UOP_W-6:UPC_W];
  end

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state <= sIdle;
      upc   <= '0;
      level <= '0;
      done  <= 1'b0;
    end else begin
      state <= stateNext;
      upc   <= upcNext;
      level <= levelNext;
      done  <= doneNext;
    end
  end

  // Return addresses are data only; their contents after reset are irrelevant.
  always_ff @(posedge iClock) begin
    if (push) stack[pushIdx] <= upcInc;
  end

  always_comb begin
    stateNext = state;
    upcNext   = upc;
    levelNext = level;
    doneNext  = 1'b0;
    case (state)
      sIdle: begin
        if (iStart) begin
          upcNext   = iFlowIdx;
          stateNext = sRun;
        end
      end
      sRun: begin
        if (iAbort) begin
          stateNext = sIdle;
          levelNext = '0;
        end else begin
          case (sq)
            SQ_JMP: upcNext = target;
            SQ_CALL: begin
              if (canPush) begin
                upcNext   = target;
                levelNext = level + LVL_W'(1);
              end else begin
                stateNext = sFault;
              end
            end
            SQ_RET: begin
              if (canPop) begin
                upcNext   = stack[popIdx];
                levelNext = level - LVL_W'(1);
              end else begin
                stateNext = sFault;
              end
            end
            SQ_WAIT: begin
              if (iMemReady) upcNext = upcInc;
            end
            default: begin
              if (eofTaken) begin
                stateNext = sIdle;
                doneNext  = 1'b1;
                levelNext = '0;
              end else begin
                upcNext = upcInc;
              end
            end
          endcase
        end
      end
      sFault: stateNext = sFault;
      default: stateNext = sIdle;
    endcase
  end

  always_comb begin
    oBusy  = (state == sRun);
    oExec  = (state == sRun) && !iAbort && !stall && !stackErr;
    oFault = (state == sFault);
  end

  assign oUpc        = upc;
  assign oDone       = done;
  assign oStackLevel = level;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Self-checking bench for dzcpu_useq: a behavioural micro-ROM feeds iUop from oUpc,
// and every cycle's expected outputs go through a queue before being compared.
module tb_dzcpu_useq;

  logic        iClock = 1'b0;
  logic        iReset, iStart, iMemReady, iAbort;
  logic [7:0]  iFlowIdx;
  logic [15:0] iUop;
  logic [3:0]  iFlags;
  logic [7:0]  oUpc;
  logic        oExec, oBusy, oDone, oFault;
  logic [2:0]  oStackLevel;

  logic [15:0] rom [256];

  typedef struct {
    logic       rst, start;
    logic [7:0] idx;
    logic [3:0] flags;
    logic       abort, mr;
    logic [7:0] eUpc;
    logic       eExec, eBusy, eDone, eFault;
    logic [2:0] eLvl;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  dzcpu_useq #(.UPC_W(8), .UOP_W(16), .STACK_DEPTH(4), .LVL_W(3)) dut (
    .iClock(iClock), .iReset(iReset), .iStart(iStart), .iFlowIdx(iFlowIdx),
    .iUop(iUop), .iFlags(iFlags), .iMemReady(iMemReady), .iAbort(iAbort),
    .oUpc(oUpc), .oExec(oExec), .oBusy(oBusy), .oDone(oDone),
    .oFault(oFault), .oStackLevel(oStackLevel)
  );

  always #5 iClock = ~iClock;
  always_comb iUop = rom[oUpc];

  function automatic logic [15:0] mk(input logic [2:0] sq, input logic [1:0] cs, input logic [7:0] t);
    return {sq, cs, 3'b000, t};
  endfunction

  function automatic vec_t v(input logic rst, input logic start, input logic [7:0] idx,
                             input logic [3:0] flags, input logic abort, input logic mr,
                             input logic [7:0] eUpc, input logic eExec, input logic eBusy,
                             input logic eDone, input logic eFault, input logic [2:0] eLvl);
    vec_t r;
    r.rst = rst; r.start = start; r.idx = idx; r.flags = flags; r.abort = abort; r.mr = mr;
    r.eUpc = eUpc; r.eExec = eExec; r.eBusy = eBusy; r.eDone = eDone; r.eFault = eFault;
    r.eLvl = eLvl;
    return r;
  endfunction

  task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, then sample mid-cycle.
  task automatic step(input vec_t x);
    vec_t e;
    @(negedge iClock);
    iReset = x.rst; iStart = x.start; iFlowIdx = x.idx; iFlags = x.flags;
    iAbort = x.abort; iMemReady = x.mr;
    expQ.push_back(x);
    #2;
    e = expQ.pop_front();
    cmp("upc",   checks, 32'(oUpc),        32'(e.eUpc));
    cmp("exec",  checks, 32'(oExec),       32'(e.eExec));
    cmp("busy",  checks, 32'(oBusy),       32'(e.eBusy));
    cmp("done",  checks, 32'(oDone),       32'(e.eDone));
    cmp("fault", checks, 32'(oFault),      32'(e.eFault));
    cmp("level", checks, 32'(oStackLevel), 32'(e.eLvl));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(3'b000, 2'd0, 8'h00);
    rom[8'h00] = mk(3'b001, 2'd0, 8'h00);
    rom[8'h22] = mk(3'b001, 2'd0, 8'h00);
    rom[8'h30] = mk(3'b010, 2'd3, 8'h00);
    rom[8'h31] = mk(3'b001, 2'd0, 8'h00);
    rom[8'h40] = mk(3'b101, 2'd0, 8'h60);
    rom[8'h60] = mk(3'b101, 2'd0, 8'h70);
    rom[8'h70] = mk(3'b110, 2'd0, 8'h00);
    rom[8'h61] = mk(3'b110, 2'd0, 8'h00);
    rom[8'h41] = mk(3'b001, 2'd0, 8'h00);
    rom[8'hC0] = mk(3'b011, 2'd0, 8'h00);
    rom[8'hC1] = mk(3'b001, 2'd0, 8'h00);
    rom[8'hD0] = mk(3'b100, 2'd0, 8'hD8);
    rom[8'hD8] = mk(3'b001, 2'd0, 8'h00);
    rom[8'h50] = mk(3'b111, 2'd0, 8'h00);
    rom[8'h51] = mk(3'b001, 2'd0, 8'h00);
    rom[8'hA0] = mk(3'b101, 2'd0, 8'hA8);
    rom[8'hA8] = mk(3'b101, 2'd0, 8'hB0);
    for (int i = 0; i < 5; i++) rom[8'h80 + i] = mk(3'b101, 2'd0, 8'(8'h81 + i));
    rom[8'h90] = mk(3'b110, 2'd0, 8'h00);

    //       rst st idx    flags   ab mr   upc    ex bz dn ft lvl
    tbl.push_back(v(0, 0, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'h20, 4'h0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h20, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h21, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h22, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'h30, 4'h0, 0, 1, 8'h22, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h30, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h31, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'h30, 4'h0, 0, 1, 8'h31, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h8, 0, 1, 8'h30, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'h40, 4'h0, 0, 1, 8'h30, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h40, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h60, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h70, 1, 1, 0, 0, 2));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h61, 1, 1, 0, 0, 1));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h41, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'hC0, 4'h1, 0, 1, 8'h41, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h1, 0, 1, 8'hC0, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hC1, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 1, 8'hD0, 4'h0, 0, 1, 8'hC1, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hD0, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hD8, 1, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hD8, 0, 0, 1, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 1, 1, 8'hD8, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hD8, 0, 0, 0, 0, 0));

    iReset = 1'b0; iStart = 1'b0; iFlowIdx = '0; iFlags = '0; iAbort = 1'b0; iMemReady = 1'b1;
    repeat (2) @(posedge iClock);

    foreach (tbl[i]) step(tbl[i]);

    // WAIT stall for three cycles, with a stray iStart in RUN that must be ignored.
    step(v(1, 1, 8'h50, 4'h0, 0, 0, 8'hD8, 0, 0, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 0, 8'h50, 0, 1, 0, 0, 0));
    step(v(1, 1, 8'h99, 4'h0, 0, 0, 8'h50, 0, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 0, 8'h50, 0, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h50, 1, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h51, 1, 1, 0, 0, 0));
    // Address wrap from FF to 00.
    step(v(1, 1, 8'hFF, 4'h0, 0, 1, 8'h51, 0, 0, 1, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hFF, 1, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h00, 1, 1, 0, 0, 0));
    // Abort at stack level 2.
    step(v(1, 1, 8'hA0, 4'h0, 0, 1, 8'h00, 0, 0, 1, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hA0, 1, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hA8, 1, 1, 0, 0, 1));
    step(v(1, 0, 8'h00, 4'h0, 1, 1, 8'hB0, 0, 1, 0, 0, 2));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'hB0, 0, 0, 0, 0, 0));
    // Stack overflow on the fifth nested CALL.
    step(v(1, 1, 8'h80, 4'h0, 0, 1, 8'hB0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'(8'h80 + i), 1, 1, 0, 0, 3'(i)));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h84, 0, 1, 0, 0, 4));
    step(v(1, 1, 8'h20, 4'h0, 1, 1, 8'h84, 0, 0, 0, 1, 4));
    step(v(0, 0, 8'h00, 4'h0, 0, 1, 8'h84, 0, 0, 0, 1, 4));
    // RET with an empty stack.
    step(v(1, 1, 8'h90, 4'h0, 0, 1, 8'h00, 0, 0, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h90, 0, 1, 0, 0, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h90, 0, 0, 0, 1, 0));
    step(v(0, 0, 8'h00, 4'h0, 0, 1, 8'h90, 0, 0, 0, 1, 0));
    step(v(1, 0, 8'h00, 4'h0, 0, 1, 8'h00, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
